result_drain: RTL and testbench
===============================

# result_drain

Streams the convolution results out of the result-save RAM once the IMG2COL/GEMM engine reports completion. It sits directly downstream of the GEMM top and takes over the read-only use of the result RAM port after `w_done`. It issues sequential reads, absorbs the RAM's 1-cycle read latency in a 2-entry output FIFO, and presents results on a valid/ready stream with a last-beat marker.

## Interface
- `ADDR_W`, default 12: result RAM address width.
- `DATA_W`, default 32: result word width. Results are signed two's complement.
- `clk` input 1: the single clock. Reset is synchronous and active-high.
- `rst` input 1: synchronous active-high reset.
- `start` input 1: one-cycle pulse, normally driven from `w_done`; ignored unless the state is IDLE.
- `result_count` input ADDR_W+1: number of words to drain; sampled on an accepted `start`.
- `ram_en` output 1: result RAM read enable. The block never drives write enable.
- `ram_addr` output ADDR_W: result RAM read address.
- `ram_dout` input DATA_W: RAM read data, valid 1 cycle after the `ram_en` cycle.
- `out_data` output DATA_W: stream data.
- `out_valid` output 1: stream valid.
- `out_ready` input 1: stream ready.
- `out_last` output 1: high together with `out_valid` on the final word.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the final word is accepted.

## Operation
- **States.**
  - IDLE → STREAM on `start` when `result_count` ≠ 0.
  - IDLE → FINISH on `start` when `result_count` = 0.
  - STREAM → FINISH when all words have been issued, are no longer in flight, and the FIFO is empty.
  - FINISH → IDLE unconditionally. `done` = 1 in FINISH.
- **Counters.**
  - `rd_ptr`: ADDR_W bits, reset to 0 on an accepted `start`; its value drives `ram_addr`.
  - `issued`: ADDR_W+1 bits.
  - `accepted`: ADDR_W+1 bits.
  - All counters are cleared on an accepted `start`.
  - Addresses run 0 .. `result_count`−1. The address never wraps: reads stop once `issued` = `result_count`.
- **Read issue.** `ram_en` = STREAM and (`issued` < `result_count`) and (`fifo_count` + `inflight` − `pop` < 2).
  - `inflight` is the registered `ram_en` from the previous cycle.
  - `pop` = `out_valid` & `out_ready` in the current cycle.
  - Each issue increments `rd_ptr` and `issued`.
- **FIFO.** 2 entries.
  - Push when `inflight` = 1, writing `ram_dout`.
  - Pop on handshake.
  - Push and pop in the same cycle keeps the count unchanged.
  - Overflow is impossible by construction; the bench asserts this.
- **Stream output.**
  - `out_valid` = FIFO not empty; `out_data` = FIFO head.
  - `out_data` stays stable while `out_valid` is high and `out_ready` is low.
- **Last beat.** `out_last` = `out_valid` and (`accepted` = `result_count` − 1).
- **`start` while busy.** Ignored; the counters are not disturbed.
- **`rst` at any time.** Returns to IDLE, clears all counters and the FIFO, and drops any in-flight read.

## Timing
- **Reset values.** `ram_en` 0, `ram_addr` 0, `out_valid` 0, `out_last` 0, `out_data` 0, `busy` 0, `done` 0.
- **Start-up sequence.** With `start` in cycle N:
  - N+1: `ram_en` = 1, `ram_addr` = 0.
  - N+2: `ram_dout` is valid.
  - N+3: first `out_valid`.
- **Throughput.** With `out_ready` held high, one word per cycle. `count` words take N+3 .. N+2+count.
  - `done` is high in cycle N+3+count.
  - The block is ready for a new `start` in cycle N+4+count.
- **`result_count` = 0.** `done` in cycle N+1; no `ram_en`, no `out_valid`.
- **Backpressure.** While `out_ready` is low:
  - at most 2 words are buffered;
  - `ram_en` drops within 1 cycle;
  - no word is lost or duplicated.
- **`done` width.** Exactly 1 cycle wide and never coincident with `out_valid`.

## Configuration
- **`RESULT_RELU_EN` defined.** Each word is clamped at FIFO push time: if the sign bit is 1, the stored value is 0; otherwise it passes unchanged. Latency is unchanged.
- **`RESULT_RELU_EN` undefined.** Words pass bit-exact.

## Structure
- **Shared package `result_drain_pkg`:**
  - state enum {IDLE, STREAM, FINISH};
  - `DRAIN_FIFO_DEPTH` = 2;
  - `relu` function (guarded by `RESULT_RELU_EN`).
- **Sub-module `drain_fifo2`.**
  - Parameter `DATA_W`.
  - Ports: push, pop, din, dout, count[1:0], empty, full.
  - Synchronous active-high reset.
- **Top-level composition.** Counters, FSM, issue logic and the ReLU stage live in `result_drain`.

## Test plan
- **Basic drain.** `result_count` = 4, RAM preloaded 10, 20, 30, 40, `out_ready` = 1.
  - `out_valid` in cycles N+3..N+6 with those values.
  - `out_last` on 40; `done` at N+7.
- **Backpressure.** `result_count` = 8, `out_ready` toggled 1,0,0,1,0,1,…
  - All 8 words arrive in order with no duplicates.
  - FIFO count ≤ 2 throughout.
  - Number of `ram_en` cycles = 8.
- **Zero length.** `result_count` = 0.
  - `done` at N+1; `ram_en` and `out_valid` never assert.
- **Busy and reset.**
  - A second `start` during STREAM is ignored; output is unchanged.
  - `rst` asserted after 3 accepted words: all outputs return to reset values next cycle.
  - A new `start` with `result_count` = 2 then drains addresses 0, 1.
- **Configuration.** RAM words −5, 7, 0x8000_0000.
  - With `RESULT_RELU_EN`: 0, 7, 0.
  - Without: −5, 7, 0x8000_0000.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result drain path.
// Optional feature: define RESULT_RELU_EN to clamp negative results to zero.
package result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } drain_state_e;

  localparam logic [1:0] DRAIN_FIFO_DEPTH = 2'd2;

`ifdef RESULT_RELU_EN
  // A word survives the clamp only when its sign bit is clear.
  function automatic logic relu_keep(input logic sign_bit);
    return ~sign_bit;
  endfunction
`endif

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry FIFO that absorbs the result RAM read latency in front of the stream port.
module drain_fifo2
  import result_drain_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count,
  output logic              empty,
  output logic              full
);

  logic [1:0][DATA_W-1:0] mem_q, mem_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [1:0]             count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == DRAIN_FIFO_DEPTH);

endmodule

// File: rtl/result_drain.sv
// Streams result RAM words out on a valid/ready port after the GEMM engine completes.
// Optional feature: define RESULT_RELU_EN to clamp negative words to zero at FIFO push.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   result_count,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   accepted_q, accepted_d;
  logic [ADDR_W:0]   total_q, total_d;
  logic              inflight_q, inflight_d;

  logic              pop;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] push_data;

`ifdef RESULT_RELU_EN
  assign push_data = relu_keep(ram_dout[DATA_W-1]) ? ram_dout : '0;
`else
  assign push_data = ram_dout;
`endif

  drain_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .din  (push_data),
    .dout (out_data),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  // A read is only issued when its data is guaranteed a FIFO slot on arrival.
  assign ram_en = (state_q == STREAM) && (issued_q < total_q) &&
                  (occupancy < 3'd2) && !(fifo_full && !pop);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    total_d    = total_q;
    inflight_d = ram_en;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d   = '0;
          issued_d   = '0;
          accepted_d = '0;
          total_d    = result_count;
          state_d    = (result_count == '0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        if (ram_en) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          issued_d = issued_q + (ADDR_W+1)'(1);
        end
        if (pop) begin
          accepted_d = accepted_q + (ADDR_W+1)'(1);
        end
        // Leave once nothing is in flight and this cycle's pop empties the FIFO.
        if ((issued_q == total_q) && !inflight_q && (fifo_count == {1'b0, pop})) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      total_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      total_q    <= total_d;
      inflight_q <= inflight_d;
    end
  end

  assign ram_addr = rd_ptr_q;
  assign out_last = out_valid && (accepted_q == total_q - (ADDR_W+1)'(1));
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain against a queue-based model of the drained stream.
// Honours RESULT_RELU_EN when computing the expected words.
module tb_result_drain;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   result_count;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int vectors     = 0;
  int miscompares = 0;

  result_drain #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .result_count(result_count),
    .ram_en      (ram_en),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Result RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_en) ram_dout <= ram[ram_addr];
  end

  function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] w);
`ifdef RESULT_RELU_EN
    return w[DATA_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // mode 0: always ready, 1: 1,0,0,1,0,1 pattern, 2: random
  function automatic logic next_ready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 6) == 0) || ((k % 6) == 3) || ((k % 6) == 5);
    return 1'($urandom % 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ram_en"}, ram_en, 0);
    checkOutput({tag, "_ram_addr"}, ram_addr, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_last"}, out_last, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Runs one drain of cnt words; optionally fires an ignored start at cycle busy_k
  // or resets the block once rst_after words have been accepted.
  task automatic applyStimulus(input int cnt, input int mode, input int busy_k, input int rst_after);
    logic [DATA_W-1:0] expq[$];
    int idx;
    int en_cnt;
    bit seen_done;
    expq.delete();
    for (int i = 0; i < cnt; i++) expq.push_back(model_word(ram[i]));
    idx       = 0;
    en_cnt    = 0;
    seen_done = 1'b0;
    @(posedge clk); #1;
    start        = 1'b1;
    result_count = (ADDR_W+1)'(cnt);
    out_ready    = next_ready(mode, 0);
    for (int k = 0; k < 400 && !seen_done; k++) begin
      @(negedge clk);
      if (ram_en) begin
        checkOutput("ram_addr", ram_addr, en_cnt);
        en_cnt++;
      end
      checkOutput("fifo_bound", dut.fifo_count <= 2, 1);
      if (mode == 0) begin
        checkOutput("valid_timing", out_valid, (cnt > 0) && (k >= 3) && (k <= cnt + 2));
        checkOutput("en_timing", ram_en, (k >= 1) && (k <= cnt));
      end
      if (out_valid) begin
        if (idx < cnt) checkOutput("out_data", out_data, expq[idx]);
        else checkOutput("extra_word", idx, cnt - 1);
        checkOutput("out_last", out_last, idx == cnt - 1);
        checkOutput("done_vs_valid", done, 0);
        if (out_ready) idx++;
      end
      if (done) begin
        seen_done = 1'b1;
        checkOutput("words_before_done", idx, cnt);
        if (mode == 0) checkOutput("done_cycle", k, (cnt == 0) ? 1 : cnt + 3);
      end
      if (rst_after > 0 && idx == rst_after) begin
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("mid_reset");
        return;
      end
      @(posedge clk); #1;
      start = (k + 1 == busy_k);
      if (k + 1 == busy_k) result_count = (ADDR_W+1)'(cnt + 5);
      out_ready = next_ready(mode, k + 1);
    end
    checkOutput("done_seen", seen_done, 1);
    checkOutput("ram_en_cycles", en_cnt, cnt);
    @(negedge clk);
    checkOutput("idle_after_done_busy", busy, 0);
    checkOutput("done_width", done, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    result_count = '0;
    out_ready    = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] basic drain");
    ram[0] = 32'd10; ram[1] = 32'd20; ram[2] = 32'd30; ram[3] = 32'd40;
    applyStimulus(4, 0, -1, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) ram[i] = $urandom;
    applyStimulus(8, 1, -1, 0);

    $display("[TB] zero length");
    applyStimulus(0, 0, -1, 0);

    $display("[TB] start while busy");
    for (int i = 0; i < 6; i++) ram[i] = $urandom;
    applyStimulus(6, 0, 4, 0);

    $display("[TB] reset mid drain");
    for (int i = 0; i < 8; i++) ram[i] = $urandom;
    applyStimulus(8, 0, -1, 3);
    ram[0] = 32'h1111_0000; ram[1] = 32'h2222_0001;
    applyStimulus(2, 0, -1, 0);

    $display("[TB] signed words");
    ram[0] = 32'hFFFF_FFFB; ram[1] = 32'd7; ram[2] = 32'h8000_0000;
    applyStimulus(3, 2, -1, 0);

    $display("[TB] random drains");
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) ram[i] = $urandom;
      applyStimulus(n, (r % 2 == 0) ? 2 : 0, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
